tx_scheduler: RTL and testbench
===============================

# tx_scheduler

Round-robin scheduler sharing the 4-bit parallel-load serial transmitter register among `N_REQ` requesters. It picks one pending requester and presents its word on `data_out` with a one-cycle `load` pulse, then waits for the transmitter's `fn` (frame finished) before the next grant. A watchdog aborts a frame whose `fn` never arrives. It sits between the requesting client blocks and the transmitter's `load`/`data_in`/`fn` pins.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 4, word width; matches transmitter `data_in`
- `TIMEOUT`, 64, max WAIT cycles before abort (≥ 8)
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low; sampled on `clk` rising edge
- `req`  in  N_REQ  request per requester; held high until its grant
- `req_data`  in  N_REQ*DATA_W  requester i word at bits [i*DATA_W +: DATA_W]
- `fn`  in  1  transmitter frame-finished flag
- `load`  out  1  one-cycle load strobe to transmitter
- `data_out`  out  DATA_W  word to transmitter `data_in`; stable from LOAD until next LOAD
- `grant`  out  N_REQ  one-hot, one-cycle pulse coincident with `load`
- `cur_id`  out  $clog2(N_REQ)  index of requester being served
- `busy`  out  1  high in LOAD, WAIT, GAP
- `err`  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, LOAD, WAIT, GAP.
- IDLE: if `|req`, winner = first set bit searching upward from `ptr` (wrapping at N_REQ-1→0); next state LOAD; `data_out` ← winner's word, `cur_id` ← winner. No request: stay IDLE.
- LOAD (1 cycle): `load`=1, `grant[cur_id]`=1, `busy`=1; wait counter cleared; → WAIT.
- WAIT: `fn` ignored in the first WAIT cycle (stale flag from the previous frame); from the second cycle on, `fn`=1 → GAP, `ptr` ← cur_id+1 mod N_REQ.
- Watchdog: counter increments each WAIT cycle; if it reaches TIMEOUT-1 without qualifying `fn`, `err` pulses the cycle GAP is entered and `ptr` advances as on success.
- GAP (1 cycle): `busy`=1, no grant; → IDLE. Guarantees a `load` never lands in consecutive frames without a gap.
- `req` changes outside IDLE are ignored; a request dropped before its grant is never served.
- Round-robin fairness: with all requests asserted, grant order is ptr, ptr+1, …; no requester waits more than N_REQ-1 frames.

## Timing
- Reset (`reset`=0 at an edge): state IDLE, `ptr`=0, counter 0; `load`, `grant`, `busy`, `err`, `data_out`, `cur_id` all 0 next cycle. Applies mid-frame; an aborted frame raises no `err`.
- All outputs registered; no combinational input→output path.
- Request-to-load latency: `req` seen in IDLE at edge k → `load`/`grant` high in cycle k+1.
- Minimum frame period: LOAD + 2 WAIT + GAP + IDLE = 5 cycles.
- `fn` and watchdog expiry in the same cycle: `fn` wins, no `err`.
- `ptr` wraps N_REQ-1 → 0; when N_REQ is not a power of two, modulo arithmetic is explicit.

## Structure
- Package `tx_sched_pkg`: state enum (`IDLE`, `LOAD`, `WAIT`, `GAP`) and default constants for `N_REQ`, `DATA_W`, `TIMEOUT`.
- Sub-module `rr_arbiter`: combinational rotating-priority pick (`req`, `ptr` → `winner`, `valid`). FSM, counter and output registers live in `tx_scheduler`.

## Test plan
- Single request: `req`=4'b0010, word 4'h6, `fn` pulsed 5 cycles after `load` → one `load` with `data_out`=4'h6, `grant`=4'b0010, `cur_id`=1, `busy` drops after GAP, `err`=0.
- All four requesting, words 1,2,3,4, `fn` returned each frame → grants in order 0,1,2,3,0; `data_out` follows 1,2,3,4,1.
- Wrap: after serving id 3 with `req`=4'b1001 → next grant id 0, then id 3.
- Watchdog: `fn` held 0 → `err` pulses once, TIMEOUT WAIT cycles after `load`; next pending request granted after GAP+IDLE.
- Stale `fn`: `fn` held 1 across LOAD and the first WAIT cycle → frame ends on the second WAIT cycle, not earlier.
- Reset mid-WAIT: `reset`=0 one cycle → all outputs 0 next cycle, `ptr`=0, no `err`; a held request is re-granted starting from id 0.

Source files
------------

// File: rtl/tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// tx_sched_pkg
// Shared types and default parameters for the transmitter scheduler.
//   state_e      : scheduler FSM states (IDLE, LOAD, WAIT, GAP)
//   N_REQ_DEF    : default number of requesters
//   DATA_W_DEF   : default word width (transmitter data_in width)
//   TIMEOUT_DEF  : default watchdog limit in WAIT cycles
// -----------------------------------------------------------------------------
package tx_sched_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int DATA_W_DEF  = 4;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational rotating-priority pick: the first set request bit found when
// searching upward from ptr_i, wrapping from N_REQ-1 back to 0.
//   req_i    in  N_REQ          request vector
//   ptr_i    in  $clog2(N_REQ)  highest-priority index this round
//   winner_o out $clog2(N_REQ)  selected requester (0 when valid_o is low)
//   valid_o  out 1              at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] ptr_i,
  output logic [$clog2(N_REQ)-1:0] winner_o,
  output logic                     valid_o
);

  localparam int              ID_W  = $clog2(N_REQ);
  localparam logic [ID_W:0]   N_EXT = (ID_W+1)'(N_REQ);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      sum;

  // Rotate the request vector so bit 0 of rot corresponds to ptr_i.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign rot     = req_dbl[N_REQ-1:0];

  always_comb begin
    off     = '0;
    valid_o = 1'b0;
    // Descending scan so the lowest set offset is the one left standing.
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        off     = ID_W'(j);
        valid_o = 1'b1;
      end
    end
    // Map the offset back to an absolute index; explicit modulo so
    // non-power-of-two N_REQ wraps correctly.
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= N_EXT) begin
      sum = sum - N_EXT;
    end
    winner_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/tx_scheduler.sv
// -----------------------------------------------------------------------------
// tx_scheduler
// Round-robin scheduler sharing one parallel-load serial transmitter among
// N_REQ requesters. A pending requester is picked, its word is presented on
// data_out with a one-cycle load/grant pulse, and the next grant waits for
// the transmitter's fn (frame finished). A watchdog aborts frames whose fn
// never arrives.
//
// Handshake: a requester holds req[i] high until it sees grant[i]; grant is a
// one-cycle pulse coincident with load and is the only acknowledgement.
// req is only sampled in IDLE.
//
// Ports
//   clk          in   clock, rising edge
//   reset        in   synchronous, active-low
//   req          in   N_REQ         request per requester
//   req_data     in   N_REQ*DATA_W  word of requester i at [i*DATA_W +: DATA_W]
//   fn           in   transmitter frame-finished flag
//   load         out  one-cycle load strobe
//   data_out     out  DATA_W        word to transmitter, held until next load
//   grant        out  N_REQ         one-hot pulse with load
//   cur_id       out  $clog2(N_REQ) requester being served
//   busy         out  high in LOAD, WAIT, GAP
//   err          out  one-cycle pulse on watchdog abort
//   dbg_state_o  out  2             current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic                      fn,
  output logic                      load,
  output logic [DATA_W-1:0]         data_out,
  output logic [N_REQ-1:0]          grant,
  output logic [$clog2(N_REQ)-1:0]  cur_id,
  output logic                      busy,
  output logic                      err,
  output logic [1:0]                dbg_state_o
);

  localparam int                ID_W    = $clog2(N_REQ);
  localparam int                CNT_W   = $clog2(TIMEOUT);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic [ID_W-1:0]     winner;
  logic                arb_valid;
  logic [ID_W-1:0]     next_ptr;
  logic [DATA_W-1:0]   win_word;
  logic                fn_qual;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .valid_o  (arb_valid)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i)) begin
        win_word = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (cur_id_q == LAST_ID) ? '0 : cur_id_q + ID_W'(1);

  // fn in the first WAIT cycle (cnt_q == 0) may be left over from the
  // previous frame, so it only counts from the second WAIT cycle on.
  assign fn_qual = fn && (cnt_q != '0);

  // Outputs are registered: each *_d is the value for the state being entered.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_id_d = cur_id_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    grant_d  = '0;
    load_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d         = LOAD;
          cur_id_d        = winner;
          data_d          = win_word;
          load_d          = 1'b1;
          grant_d[winner] = 1'b1;
        end
      end
      LOAD: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Qualified fn takes priority over a simultaneous watchdog expiry.
        if (fn_qual) begin
          state_d = GAP;
          ptr_d   = next_ptr;
        end else if (cnt_q == CNT_MAX) begin
          state_d = GAP;
          ptr_d   = next_ptr;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign load        = load_q;
  assign data_out    = data_q;
  assign grant       = grant_q;
  assign cur_id      = cur_id_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tx_scheduler
// Directed bench for tx_scheduler (N_REQ=4, DATA_W=4, TIMEOUT=16). Inputs are
// driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tx_scheduler;

  localparam int N_REQ   = 4;
  localparam int DATA_W  = 4;
  localparam int TIMEOUT = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     reset;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*DATA_W-1:0]  req_data;
  logic                     fn;
  logic                     load;
  logic [DATA_W-1:0]        data_out;
  logic [N_REQ-1:0]         grant;
  logic [1:0]               cur_id;
  logic                     busy;
  logic                     err;
  logic [1:0]               dbg_state;

  tx_scheduler #(
    .N_REQ   (N_REQ),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .fn          (fn),
    .load        (load),
    .data_out    (data_out),
    .grant       (grant),
    .cur_id      (cur_id),
    .busy        (busy),
    .err         (err),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance until load is seen or the budget runs out; reports cycles waited.
  task automatic wait_load(input int budget, output int waited);
    waited = 0;
    while (load !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"},     32'(load),      0);
    chk({tag, "_grant"},    32'(grant),     0);
    chk({tag, "_busy"},     32'(busy),      0);
    chk({tag, "_err"},      32'(err),       0);
    chk({tag, "_data_out"}, 32'(data_out),  0);
    chk({tag, "_cur_id"},   32'(cur_id),    0);
    chk({tag, "_state"},    32'(dbg_state), 32'(S_IDLE));
  endtask

  task automatic chk_grant(input string tag, input logic [3:0] exp_grant,
                           input int exp_id, input logic [3:0] exp_word);
    chk({tag, "_load"},     32'(load),     1);
    chk({tag, "_grant"},    32'(grant),    32'(exp_grant));
    chk({tag, "_cur_id"},   32'(cur_id),   32'(exp_id));
    chk({tag, "_data_out"}, 32'(data_out), 32'(exp_word));
    chk({tag, "_busy"},     32'(busy),     1);
  endtask

  // One grant followed by fn returned on the second WAIT cycle; ends on the
  // GAP cycle.
  task automatic serve_frame(input string tag, input logic [3:0] exp_grant,
                             input int exp_id, input logic [3:0] exp_word,
                             input int exp_wait);
    int w;
    wait_load(12, w);
    chk({tag, "_latency"}, 32'(w), 32'(exp_wait));
    chk_grant(tag, exp_grant, exp_id, exp_word);
    step(1);
    step(1); fn = 1'b1;
    step(1); fn = 1'b0;
    chk({tag, "_gap_state"}, 32'(dbg_state), 32'(S_GAP));
    chk({tag, "_gap_err"},   32'(err),       0);
    chk({tag, "_gap_grant"}, 32'(grant),     0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int errs;
    reset    = 1'b0;
    req      = '0;
    req_data = '0;
    fn       = 1'b0;

    step(2);
    chk_all_zero("reset");
    reset = 1'b1;
    step(1);

    // Single request, fn five cycles after load.
    req      = 4'b0010;
    req_data = 16'h0060;
    wait_load(12, w);
    chk("single_latency", 32'(w), 1);
    chk_grant("single", 4'b0010, 1, 4'h6);
    req = '0;
    step(4);
    chk("single_wait_busy",  32'(busy),      1);
    chk("single_wait_state", 32'(dbg_state), 32'(S_WAIT));
    step(1); fn = 1'b1;
    step(1); fn = 1'b0;
    chk("single_gap_state", 32'(dbg_state), 32'(S_GAP));
    chk("single_gap_busy",  32'(busy),      1);
    chk("single_gap_err",   32'(err),       0);
    step(1);
    chk("single_idle_busy",  32'(busy),      0);
    chk("single_idle_state", 32'(dbg_state), 32'(S_IDLE));
    chk("single_data_hold",  32'(data_out),  32'h6);

    // Short reset brings ptr back to 0.
    reset = 1'b0;
    step(1);
    reset = 1'b1;

    // All requesting: order 0,1,2,3 then wrap with req=1001 gives 0 then 3.
    req      = 4'b1111;
    req_data = {4'h4, 4'h3, 4'h2, 4'h1};
    serve_frame("rr0", 4'b0001, 0, 4'h1, 1);
    serve_frame("rr1", 4'b0010, 1, 4'h2, 2);
    serve_frame("rr2", 4'b0100, 2, 4'h3, 2);
    serve_frame("rr3", 4'b1000, 3, 4'h4, 2);
    req = 4'b1001;
    serve_frame("wrap0", 4'b0001, 0, 4'h1, 2);
    req = 4'b1000;
    serve_frame("wrap3", 4'b1000, 3, 4'h4, 2);

    // Watchdog: id1 never sees fn; pending 0101 must go to id2 (ptr=2).
    req      = 4'b0010;
    req_data = {4'h4, 4'h9, 4'hA, 4'h1};
    wait_load(12, w);
    chk("wdog_latency", 32'(w), 2);
    chk_grant("wdog", 4'b0010, 1, 4'hA);
    req  = 4'b0101;
    errs = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      step(1);
      if (err) errs++;
    end
    chk("wdog_no_early_err", 32'(errs),      0);
    chk("wdog_last_wait",    32'(dbg_state), 32'(S_WAIT));
    step(1);
    chk("wdog_err_pulse", 32'(err),       1);
    chk("wdog_gap_state", 32'(dbg_state), 32'(S_GAP));
    chk("wdog_gap_busy",  32'(busy),      1);
    fn = 1'b1;  // held high across the next LOAD and first WAIT cycle
    step(1);
    chk("wdog_err_single", 32'(err),  0);
    chk("wdog_idle_busy",  32'(busy), 0);

    // Stale fn: frame must end on the second WAIT cycle.
    wait_load(12, w);
    chk("stale_latency", 32'(w), 1);
    chk_grant("stale", 4'b0100, 2, 4'h9);
    req = '0;
    step(1);
    chk("stale_wait1", 32'(dbg_state), 32'(S_WAIT));
    step(1);
    chk("stale_wait2", 32'(dbg_state), 32'(S_WAIT));
    step(1);
    chk("stale_gap",     32'(dbg_state), 32'(S_GAP));
    chk("stale_gap_err", 32'(err),       0);
    fn = 1'b0;

    // Reset mid-WAIT with 1010 held: ptr=3 picks id3, after reset id1.
    req = 4'b1010;
    wait_load(12, w);
    chk("pre_rst_latency", 32'(w), 2);
    chk_grant("pre_rst", 4'b1000, 3, 4'h4);
    step(2);
    chk("pre_rst_wait", 32'(dbg_state), 32'(S_WAIT));
    reset = 1'b0;
    step(1);
    chk_all_zero("mid_rst");
    reset = 1'b1;
    step(1);
    chk_grant("post_rst", 4'b0010, 1, 4'hA);
    chk("post_rst_err", 32'(err), 0);
    req = '0;
    step(2); fn = 1'b1;
    step(1); fn = 1'b0;
    chk("post_rst_gap", 32'(dbg_state), 32'(S_GAP));
    chk("post_rst_err2", 32'(err), 0);
    step(1);
    chk("post_rst_idle_busy", 32'(busy), 0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
